pwm_wave_gen: RTL and testbench
===============================

# pwm_wave_gen

Parametrised successor to the fixed 50 %-duty square-wave generator. It accepts a frequency in Hz and a duty fraction through a valid/ready configuration port and computes the period with a multi-cycle sequential divider instead of a combinational one. It applies new settings only at period boundaries, so the output never glitches, and it drives one PWM/square output plus a period-start strobe. It sits between the control logic (keys/UART decode) and the output pin or LED driver.

## Interface
- CLK_HZ, 50_000_000: input clock frequency in Hz.
- WIDTH, 32: width of the frequency, period and counter datapath; CLK_HZ must fit in WIDTH bits.
- DUTY_W, 8: duty fraction width; duty = cfg_duty / 2^DUTY_W.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; when low the counter is held at 0 and wave is 0.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  block can accept a configuration (state IDLE).
- cfg_freq  in  WIDTH  requested output frequency in Hz.
- cfg_duty  in  DUTY_W  requested high-time fraction.
- wave  out  1  PWM output, registered.
- period_start  out  1  one-cycle pulse on the first cycle of every period (cnt==0 while running).
- cfg_err  out  1  one-cycle pulse when a configuration is rejected.

## Operation
- FSM states:
  - IDLE (cfg_ready=1): a transfer occurs when cfg_valid && cfg_ready; cfg_freq and cfg_duty are captured.
  - CHECK: validate the captured frequency.
    - If freq==0 or freq > CLK_HZ/2: pulse cfg_err and return to IDLE; the active config is unchanged.
    - Otherwise go to DIV.
  - DIV: restoring divide, one quotient bit per cycle, for exactly WIDTH cycles. period = floor(CLK_HZ / freq), always >= 2.
  - SCALE: high = (period * duty) >> DUTY_W, using a 2*WIDTH-bit product truncated to WIDTH. Because duty <= (2^DUTY_W - 1)/2^DUTY_W, high < period always.
  - PEND: wait for the commit point, write period_act/high_act, set the active flag, return to IDLE.
- Commit point:
  - If the block is not active or en=0, commit on the first PEND cycle.
  - Otherwise commit on the cycle where cnt == period_act - 1, so the next cycle starts a full new period. A running period is never truncated.
- Counter and output:
  - While active && en, cnt runs 0..period_act-1 and wraps.
  - wave = (cnt < high_act), held in registers aligned with cnt.
  - high_act == 0 gives constant low.
- Before the first successful commit, wave=0, cnt=0 and period_start=0.
- en falling: on the next cycle cnt=0 and wave=0; any pending commit proceeds immediately.
- en rising: the first cycle with en=1 is cnt=0, with a period_start pulse.
- Reset, asynchronous and possibly mid-DIV/PEND:
  - FSM returns to IDLE.
  - cnt=0, wave=0, period_start=0, cfg_err=0.
  - cfg_ready=1 after reset release.
  - Active flag cleared; period_act and high_act set to 0.

## Timing
- Transfer at edge T. CHECK at cycle T+1. DIV at cycles T+2..T+WIDTH+1. SCALE at T+WIDTH+2. First PEND cycle at T+WIDTH+3.
- Idle or disabled counter: the new params take effect at the edge ending T+WIDTH+3, and cnt=0 with the new params at T+WIDTH+4.
- cfg_ready returns to 1 in the cycle after the commit edge; cfg_err rises at T+2 for one cycle.
- cfg_valid held high while cfg_ready=0 is ignored and has no queueing.
- Output frequency = CLK_HZ / period, with truncation error from the floor.

## Structure
- Shared include sqgen_defs.vh: FSM state encodings (IDLE, CHECK, DIV, SCALE, PEND).
- Sub-module udiv_seq #(WIDTH):
  - start/busy/done handshake.
  - dividend and divisor inputs, quotient output.
  - WIDTH-cycle restoring divider.
  - Reusable by other generators.
- Top level holds the FSM, duty scaling, active registers, counter and output registers.

## Test plan
Test parameters: CLK_HZ=1000, WIDTH=16, DUTY_W=8.
- Reset release, then cfg freq=100 duty=128: cfg_err stays 0, period=10, wave shows 5 cycles high then 5 low, repeating; period_start pulses every 10 cycles.
- freq=0 and freq=501 are each rejected: a one-cycle cfg_err, no change to the running waveform, cfg_ready back to 1 at T+2.
- While running period 10, cfg freq=250 duty=64: the new period of 4 with 1 cycle high starts exactly after a full 10-cycle period, with no short pulse.
- duty=0: wave constant 0 while period_start still pulses. freq=500 duty=255: period=2, high=1.
- Toggle en low for 7 cycles mid-period: wave=0, cnt=0, no period_start pulses; on re-enable a full period restarts with period_start.
- Assert rst_n low during DIV: all outputs reset immediately; after release cfg_ready=1, wave=0, and the block is inactive until a new config is committed.

Source files
------------

// File: rtl/pwm_wave_gen_pkg.sv
// Shared types for the PWM wave generator: configuration FSM state encoding.
package pwm_wave_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_DIV,
      ST_SCALE,
      ST_PEND
   } state_e;

endpackage

// File: rtl/pwm_wave_gen_if.sv
// Configuration port of the PWM generator: valid/ready request plus a reject strobe.
interface pwm_wave_gen_if #(
   parameter int WIDTH  = 32,
   parameter int DUTY_W = 8
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [WIDTH-1:0]  cfg_freq;
   logic [DUTY_W-1:0] cfg_duty;
   logic              cfg_err;

   modport master (output cfg_valid, cfg_freq, cfg_duty, input cfg_ready, cfg_err);
   modport slave  (input cfg_valid, cfg_freq, cfg_duty, output cfg_ready, cfg_err);
endinterface

// File: rtl/pwm_wave_gen_udiv_seq.sv
// Restoring unsigned divider, one quotient bit per cycle for WIDTH cycles.
// done_o marks the final step; quotient_o is valid from the following cycle.
module udiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o
);
   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] rem_q, quo_q, div_q;
   logic [SW-1:0]    step_q;
   logic             busy_q;
   logic [WIDTH:0]   shifted, diff;

   // Quotient register doubles as the dividend shift register; diff[WIDTH] is the borrow.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, div_q};

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         div_q  <= '0;
         step_q <= '0;
         busy_q <= 1'b0;
      end else if (start_i) begin
         rem_q  <= '0;
         quo_q  <= dividend_i;
         div_q  <= divisor_i;
         step_q <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         if (!diff[WIDTH]) begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end
         step_q <= step_q + SW'(1);
         if (step_q == SW'(WIDTH - 1)) busy_q <= 1'b0;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = busy_q && (step_q == SW'(WIDTH - 1));
   assign quotient_o = quo_q;

endmodule

// File: rtl/pwm_wave_gen.sv
// PWM generator: validates a frequency/duty request, divides out the period and
// swaps the new settings in only at a period boundary so the output never glitches.
module pwm_wave_gen
   import pwm_wave_gen_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int          WIDTH  = 32,
   parameter int          DUTY_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   pwm_wave_gen_if.slave cfg,
   output logic          wave,
   output logic          period_start
);
   localparam logic [WIDTH-1:0] CLK_HZ_W = WIDTH'(CLK_HZ);
   localparam logic [WIDTH-1:0] FREQ_MAX = WIDTH'(CLK_HZ / 2);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    freq_q;
   logic [DUTY_W-1:0]   duty_q;
   logic [WIDTH-1:0]    pend_period_q, pend_high_q;
   logic [WIDTH-1:0]    period_act_q, high_act_q, cnt_q;
   logic                active_q, run_q, wave_q, pstart_q, err_q;

   logic                cfg_ok, cfg_ready_c, capture, div_start, err_set, commit;
   logic                div_busy, div_done;
   logic [WIDTH-1:0]    quotient, high_calc;
   logic [2*WIDTH-1:0]  product;
   logic [WIDTH-1:0]    period_nx, high_nx, cnt_d;
   logic                active_nx, run_nx, wave_d, pstart_d;

   assign cfg_ok = (freq_q != '0) && (freq_q <= FREQ_MAX);

   udiv_seq #(.WIDTH(WIDTH)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .dividend_i (CLK_HZ_W),
      .divisor_i  (freq_q),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quotient_o (quotient)
   );

   assign product   = {{WIDTH{1'b0}}, quotient} * {{(2*WIDTH-DUTY_W){1'b0}}, duty_q};
   assign high_calc = WIDTH'(product >> DUTY_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (cfg.cfg_valid && !div_busy) state_d = ST_CHECK;
         ST_CHECK: state_d = cfg_ok ? ST_DIV : ST_IDLE;
         ST_DIV:   if (div_done) state_d = ST_SCALE;
         ST_SCALE: state_d = ST_PEND;
         ST_PEND:  if (commit) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // A running period is only replaced on its last cycle, so it is never truncated.
   always_comb begin
      cfg_ready_c = 1'b0;
      capture     = 1'b0;
      div_start   = 1'b0;
      err_set     = 1'b0;
      commit      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cfg_ready_c = !div_busy;
            capture     = cfg.cfg_valid && !div_busy;
         end
         ST_CHECK: begin
            div_start = cfg_ok;
            err_set   = !cfg_ok;
         end
         ST_PEND:  commit = !active_q || !en || (cnt_q == period_act_q - WIDTH'(1));
         default:  ;
      endcase
   end

   // Outputs are registered images of the next counter value and the next active settings.
   always_comb begin
      period_nx = commit ? pend_period_q : period_act_q;
      high_nx   = commit ? pend_high_q   : high_act_q;
      active_nx = active_q || commit;
      run_nx    = active_nx && en;
      cnt_d     = '0;
      if (run_nx && run_q && !commit && (cnt_q != period_act_q - WIDTH'(1)))
         cnt_d = cnt_q + WIDTH'(1);
      wave_d    = run_nx && (cnt_d < high_nx);
      pstart_d  = run_nx && (cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freq_q        <= '0;
         duty_q        <= '0;
         pend_period_q <= '0;
         pend_high_q   <= '0;
         period_act_q  <= '0;
         high_act_q    <= '0;
         active_q      <= 1'b0;
         cnt_q         <= '0;
         run_q         <= 1'b0;
         wave_q        <= 1'b0;
         pstart_q      <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         if (capture) begin
            freq_q <= cfg.cfg_freq;
            duty_q <= cfg.cfg_duty;
         end
         if (state_q == ST_SCALE) begin
            pend_period_q <= quotient;
            pend_high_q   <= high_calc;
         end
         period_act_q <= period_nx;
         high_act_q   <= high_nx;
         active_q     <= active_nx;
         cnt_q        <= cnt_d;
         run_q        <= run_nx;
         wave_q       <= wave_d;
         pstart_q     <= pstart_d;
         err_q        <= err_set;
      end
   end

   assign cfg.cfg_ready = cfg_ready_c;
   assign cfg.cfg_err   = err_q;
   assign wave          = wave_q;
   assign period_start  = pstart_q;

endmodule

// File: tb/tb_pwm_wave_gen.sv
// Self-checking bench for pwm_wave_gen: directed scenarios pinned by literal waveforms,
// then random traffic compared every cycle against a behavioural model of the block.
module tb_pwm_wave_gen;
   localparam int CLK_HZ = 1000;
   localparam int WIDTH  = 16;
   localparam int DUTY_W = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic wave, period_start;

   pwm_wave_gen_if #(.WIDTH(WIDTH), .DUTY_W(DUTY_W)) cfg_bus ();

   pwm_wave_gen #(.CLK_HZ(CLK_HZ), .WIDTH(WIDTH), .DUTY_W(DUTY_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .cfg          (cfg_bus),
      .wave         (wave),
      .period_start (period_start)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   // Behavioural model: config pipeline age, active settings and position within the period.
   bit m_idle, m_rej, m_err, m_active, m_running;
   int m_cyc, m_pp, m_ph, m_period, m_high, m_phase;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_idle = 1'b1; m_rej = 1'b0; m_err = 1'b0; m_active = 1'b0; m_running = 1'b0;
      m_cyc = 0; m_pp = 0; m_ph = 0; m_period = 0; m_high = 0; m_phase = 0;
   endtask

   // Applied at each rising edge with the inputs that edge samples.
   task automatic model_update();
      int  f;
      bit  committed;
      bit  was_running;
      committed = 1'b0;
      m_err     = 1'b0;
      if (!m_idle) begin
         if (m_rej) begin
            m_idle = 1'b1;
            m_err  = 1'b1;
         end else if (m_cyc >= WIDTH + 3 &&
                      (!m_active || !en || m_phase == m_period - 1)) begin
            committed = 1'b1;
            m_idle    = 1'b1;
         end else begin
            m_cyc++;
         end
      end else if (cfg_bus.cfg_valid) begin
         f      = int'(cfg_bus.cfg_freq);
         m_rej  = (f == 0) || (f > CLK_HZ / 2);
         if (!m_rej) begin
            m_pp = CLK_HZ / f;
            m_ph = (m_pp * int'(cfg_bus.cfg_duty)) / (1 << DUTY_W);
         end
         m_idle = 1'b0;
         m_cyc  = 1;
      end
      was_running = m_running;
      if (committed) begin
         m_period = m_pp;
         m_high   = m_ph;
         m_active = 1'b1;
      end
      m_running = m_active && en;
      if (!m_running || !was_running || committed) m_phase = 0;
      else                                         m_phase = (m_phase + 1) % m_period;
   endtask

   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         check("wave",         wave,               int'(m_running && m_phase < m_high));
         check("period_start", period_start,       int'(m_running && m_phase == 0));
         check("cfg_ready",    cfg_bus.cfg_ready,  int'(m_idle));
         check("cfg_err",      cfg_bus.cfg_err,    int'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_update();
      else       model_reset();
      @(negedge clk);
   endtask

   task automatic send_cfg(input int freq, input int duty);
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_freq  = WIDTH'(freq);
      cfg_bus.cfg_duty  = DUTY_W'(duty);
      tick();
      cfg_bus.cfg_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!cfg_bus.cfg_ready && n < 3000) begin
         tick();
         n++;
      end
      check("wait_ready_timeout", int'(n >= 3000), 0);
   endtask

   task automatic record(input int n, output logic [31:0] w, output logic [31:0] p);
      w = '0;
      p = '0;
      for (int i = 0; i < n; i++) begin
         w[i] = wave;
         p[i] = period_start;
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] w, p;
      int          n;
      bit          bad;
      int          rej_freq [2];

      rst_n = 1'b0;
      en    = 1'b1;
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_freq  = '0;
      cfg_bus.cfg_duty  = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      chk_on = 1'b1;
      check("rst_wave",  wave, 0);
      check("rst_ps",    period_start, 0);
      check("rst_err",   cfg_bus.cfg_err, 0);
      check("rst_ready", cfg_bus.cfg_ready, 1);
      tick();

      // 100 Hz at half duty: period 10, five high cycles.
      send_cfg(100, 128);
      n = 1;
      while (!period_start && n < 100) begin
         tick();
         n++;
      end
      check("first_period_latency", n, WIDTH + 4);
      record(20, w, p);
      check("wave_100_128", int'(w), 32'h0007C1F);
      check("ps_100_128",   int'(p), 32'h0000401);

      // Out-of-range requests are rejected without touching the running waveform.
      rej_freq[0] = 0;
      rej_freq[1] = CLK_HZ / 2 + 1;
      foreach (rej_freq[k]) begin
         send_cfg(rej_freq[k], 128);
         tick();
         check("reject_err",   cfg_bus.cfg_err, 1);
         check("reject_ready", cfg_bus.cfg_ready, 1);
         repeat (3) tick();
      end

      // Switch to 250 Hz / quarter duty: period 4, one high cycle.
      send_cfg(250, 64);
      wait_ready();
      record(8, w, p);
      check("wave_250_64", int'(w), 32'h11);
      check("ps_250_64",   int'(p), 32'h11);

      send_cfg(100, 0);
      wait_ready();
      record(20, w, p);
      check("wave_duty0", int'(w), 0);
      check("ps_duty0",   int'(p), 32'h0000401);

      send_cfg(500, 255);
      wait_ready();
      record(4, w, p);
      check("wave_500_255", int'(w), 32'h5);
      check("ps_500_255",   int'(p), 32'h5);

      // Disable for seven cycles mid-period, then restart a full period.
      send_cfg(100, 128);
      wait_ready();
      repeat (3) tick();
      en  = 1'b0;
      bad = 1'b0;
      repeat (7) begin
         tick();
         bad |= wave | period_start;
      end
      check("disabled_quiet", int'(bad), 0);
      en = 1'b1;
      tick();
      record(11, w, p);
      check("wave_reenable", int'(w), 32'h41F);
      check("ps_reenable",   int'(p), 32'h401);

      // Asynchronous reset while the divider is running.
      send_cfg(250, 64);
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_wave", wave, 0);
      check("midrst_ps",   period_start, 0);
      check("midrst_err",  cfg_bus.cfg_err, 0);
      tick();
      #2 rst_n = 1'b1;
      check("postrst_ready", cfg_bus.cfg_ready, 1);
      check("postrst_wave",  wave, 0);
      bad = 1'b0;
      repeat (30) begin
         tick();
         bad |= wave | period_start;
      end
      check("postrst_inactive", int'(bad), 0);

      // Random requests (some invalid, some while busy) with random enable gaps.
      for (int i = 0; i < 1500; i++) begin
         if (en) begin
            if ($urandom_range(0, 23) == 0) en = 1'b0;
         end else begin
            if ($urandom_range(0, 3) == 0) en = 1'b1;
         end
         cfg_bus.cfg_valid = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 9))
            0:       cfg_bus.cfg_freq = '0;
            1:       cfg_bus.cfg_freq = WIDTH'($urandom_range(CLK_HZ / 2 + 1, 65535));
            default: cfg_bus.cfg_freq = WIDTH'($urandom_range(20, CLK_HZ / 2));
         endcase
         cfg_bus.cfg_duty = DUTY_W'($urandom_range(0, 255));
         tick();
      end
      cfg_bus.cfg_valid = 1'b0;
      en = 1'b1;
      repeat (100) tick();

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
